mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Parametrised load/store unit for the MEM stage, successor to the ID-stage memory control decode.
//  Takes one decoded access per request (size, sign, addr, data), drives byte lanes on the data bus,
//  and waits for a variable-latency ack. Returns aligned, sign/zero-extended load data.
//  Flags misalignment and bus timeout. Holds req_ready low while busy; the pipeline stalls on it.
// PARAMETERS
//  DATA_WIDTH     32   bus/register width; 32 or 64 only
//  ADDR_WIDTH     32   byte address width
//  SEL_WIDTH      DATA_WIDTH/8   byte-lane select width (derived; not overridden)
//  TIMEOUT_CYCLES 255  max cycles waiting for bus_ack; 0 = never time out
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           asynchronous reset, active low
//  req_valid     in   1           access request present
//  req_ready     out  1           unit idle, request accepted when valid&&ready
//  req_write     in   1           1 = store, 0 = load
//  req_size      in   2           0 byte, 1 half, 2 word, 3 dword (DATA_WIDTH=64 only)
//  req_sign_ext  in   1           loads: 1 sign-extend, 0 zero-extend
//  req_addr      in   ADDR_WIDTH  byte address
//  req_wdata     in   DATA_WIDTH  store data, LSB-justified
//  rsp_valid     out  1           one-cycle completion pulse
//  rsp_err       out  1           valid with rsp_valid: misaligned, illegal size, or timeout
//  rsp_rdata     out  DATA_WIDTH  extended load data; 0 for stores and errors
//  bus_en        out  1           bus request, held until bus_ack
//  bus_we        out  1           bus write
//  bus_sel       out  SEL_WIDTH   byte-lane enables
//  bus_addr      out  ADDR_WIDTH  word-aligned address (low log2(SEL_WIDTH) bits = 0)
//  bus_wdata     out  DATA_WIDTH  lane-placed store data
//  bus_ack       in   1           bus completes current access
//  bus_rdata     in   DATA_WIDTH  raw read word, valid with bus_ack
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; bus_en=0, bus_we=0,
//   bus_sel=0, bus_addr=0, bus_wdata=0; timeout counter=0. Async reset mid-access aborts it:
//   bus_en drops at once and no response is issued.
//  FSM: IDLE -> BUSY on accept of a legal access. IDLE -> RESP(err) on accept of an illegal access.
//   BUSY -> RESP on bus_ack, or on timeout. RESP -> IDLE unconditionally.
//  req_ready = (state==IDLE). All request fields are captured into registers on accept.
//  Illegal access: size 3 with DATA_WIDTH=32; half with addr[0]!=0; word with addr[1:0]!=0;
//   dword with addr[2:0]!=0. No bus cycle is issued for it.
//  Little-endian lanes: off = addr[log2(SEL_WIDTH)-1:0]. sel = ((1<<bytes)-1) << off.
//   wdata = (req_wdata masked to size) << 8*off.
//  BUSY: bus_en=1 with stable bus_we/sel/addr/wdata until bus_ack; a zero-wait ack is allowed.
//  Load: on ack, rsp_rdata = ext(bus_rdata >> 8*off, size, sign). Store: rsp_rdata = 0.
//  Timeout: counter increments each BUSY cycle without ack. At TIMEOUT_CYCLES it enters RESP with
//   rsp_err=1, drops bus_en, and clears rsp_rdata. Ack and timeout in the same cycle: ack wins.
//  RESP: rsp_valid=1 for exactly one cycle; rsp_err/rsp_rdata hold until next RESP.
//  bus_ack outside BUSY is ignored. Latency for a legal access: accept T, bus_en T+1,
//   ack at T+1 gives rsp_valid T+2 (min 2 cycles), plus N bus wait cycles.
//  Back-to-back: next request can be accepted in the cycle after RESP (IDLE).
// STRUCTURE
//  Shared header mem.v: `defines for size codes (MEM_SIZE_B/H/W/D), FSM state codes,
//   and the default timeout.
//  Sub-module mem_lane_align (combinational): size/off/sign -> sel, placed wdata, extracted rdata.
//   Instantiated once; the FSM, capture registers and counter live in mem_access_unit.
// TESTING
//  1. SB addr=0x1003 wdata=0xAB, ack next cycle -> bus_sel=1000, bus_addr=0x1000,
//     bus_wdata=0xAB000000, rsp_valid 2 cycles after accept, err=0.
//  2. LH sign addr=0x2002, bus_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001;
//     LHU same -> 0x00008001.
//  3. LW addr=0x3001 -> rsp_err=1 at T+1, bus_en never asserted, rsp_rdata=0.
//  4. TIMEOUT_CYCLES=4, no ack -> bus_en high 4 cycles, then rsp_valid+rsp_err.
//     Ack on 4th cycle -> err=0.
//  5. rst_n low while BUSY with 3 wait states -> bus_en=0 immediately, no rsp_valid, req_ready=1.
//  6. DATA_WIDTH=64: LD addr=0x8 -> bus_sel=0xFF; LB addr=0xF, bus_rdata[63:56]=0x80,
//     sign -> 0xFFFF_FFFF_FFFF_FF80.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared size codes, FSM states, default timeout and access legality check
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2,
        MEM_SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam int MEM_DEFAULT_TIMEOUT = 255;

    // An access is legal when naturally aligned; dword exists only on a 64-bit bus.
    function automatic logic mem_legal(input logic [1:0] size, input logic [2:0] lo, input logic dw64);
        return size == MEM_SIZE_D ? (dw64 && lo == 3'd0) :
               size == MEM_SIZE_W ? (lo[1:0] == 2'd0) :
               size == MEM_SIZE_H ? !lo[0] : 1'b1;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_access_unit_lane_align: byte-lane select, store data placement and load data extraction/extension
module mem_access_unit_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8,
    localparam int OFF_WIDTH  = $clog2(SEL_WIDTH)
) (
    input  logic [1:0]            size_i,
    input  logic [OFF_WIDTH-1:0]  off_i,
    input  logic                  sign_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [SEL_WIDTH-1:0]  lanes;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  msb;

    // Lanes of the access at offset 0, expanded to a bit mask; store shifted up, load shifted down then extended
    always_comb begin
        lanes = size_i == MEM_SIZE_B ? SEL_WIDTH'(1) :
                size_i == MEM_SIZE_H ? SEL_WIDTH'(3) :
                size_i == MEM_SIZE_W ? SEL_WIDTH'(15) : '1;
        for (int i = 0; i < SEL_WIDTH; i++) mask[8*i +: 8] = {8{lanes[i]}};
        shifted = rdata_i >> {off_i, 3'b000};
        msb     = size_i == MEM_SIZE_B ? shifted[7] :
                  size_i == MEM_SIZE_H ? shifted[15] :
                  size_i == MEM_SIZE_W ? shifted[31] : shifted[DATA_WIDTH-1];
        sel_o   = lanes << off_i;
        wdata_o = (wdata_i & mask) << {off_i, 3'b000};
        rdata_o = (shifted & mask) | ((sign_i && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with byte lanes, variable-latency bus handshake and timeout
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = MEM_DEFAULT_TIMEOUT,
    localparam int SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  bus_en_o,
    output logic                  bus_we_o,
    output logic [SEL_WIDTH-1:0]  bus_sel_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    localparam int OFF_WIDTH = $clog2(SEL_WIDTH);
    localparam int CNT_WIDTH = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_e            state_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic [OFF_WIDTH-1:0]  off_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  bus_en_q;
    logic                  bus_we_q;
    logic [SEL_WIDTH-1:0]  bus_sel_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  idle;
    logic                  legal;
    logic                  timed_out;
    logic [1:0]            a_size;
    logic [OFF_WIDTH-1:0]  a_off;
    logic                  a_sign;
    logic [SEL_WIDTH-1:0]  a_sel;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;

    assign idle      = state_q == ST_IDLE;
    assign legal     = mem_legal(req_size_i, req_addr_i[2:0], DATA_WIDTH == 64);
    assign timed_out = TIMEOUT_CYCLES != 0 && cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    // One aligner serves both phases: live request fields while idle, captured fields while on the bus
    assign a_size = idle ? req_size_i : size_q;
    assign a_off  = idle ? req_addr_i[OFF_WIDTH-1:0] : off_q;
    assign a_sign = idle ? req_sign_ext_i : sign_q;

    mem_access_unit_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_i  (a_size),
        .off_i   (a_off),
        .sign_i  (a_sign),
        .wdata_i (req_wdata_i),
        .rdata_i (bus_rdata_i),
        .sel_o   (a_sel),
        .wdata_o (a_wdata),
        .rdata_o (a_rdata)
    );

    // Access FSM: accept and capture, hold the bus until ack or timeout, then pulse the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            size_q      <= '0;
            sign_q      <= 1'b0;
            off_q       <= '0;
            cnt_q       <= '0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid_i) begin
                    size_q <= req_size_i;
                    sign_q <= req_sign_ext_i;
                    off_q  <= req_addr_i[OFF_WIDTH-1:0];
                    cnt_q  <= '0;
                    if (legal) begin
                        state_q     <= ST_BUSY;
                        bus_en_q    <= 1'b1;
                        bus_we_q    <= req_write_i;
                        bus_sel_q   <= a_sel;
                        bus_addr_q  <= {req_addr_i[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
                        bus_wdata_q <= a_wdata;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                ST_BUSY: if (bus_ack_i) begin
                    state_q     <= ST_RESP;
                    bus_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= bus_we_q ? '0 : a_rdata;
                end else if (timed_out) begin
                    state_q     <= ST_RESP;
                    bus_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = idle;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign bus_en_o    = bus_en_q;
    assign bus_we_o    = bus_we_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors with a transaction-level model and per-cycle compare
module tb_mem_access_unit;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid = 1'b0, we = 1'b0, sign = 1'b0, ack = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'd0, wd = 32'd0, rd = 32'd0;
    logic        ready, rsp_v, rsp_e, b_en, b_we;
    logic [31:0] rsp_d, b_addr, b_wd;
    logic [3:0]  b_sel;

    logic        valid64 = 1'b0, ack64 = 1'b0;
    logic [63:0] wd64 = 64'd0, rd64 = 64'd0;
    logic        ready64, rsp_v64, rsp_e64, b_en64, b_we64;
    logic [63:0] rsp_d64, b_wd64;
    logic [31:0] b_addr64;
    logic [7:0]  b_sel64;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut32 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_ready_o(ready), .req_write_i(we),
        .req_size_i(size), .req_sign_ext_i(sign), .req_addr_i(addr), .req_wdata_i(wd),
        .rsp_valid_o(rsp_v), .rsp_err_o(rsp_e), .rsp_rdata_o(rsp_d), .bus_en_o(b_en), .bus_we_o(b_we),
        .bus_sel_o(b_sel), .bus_addr_o(b_addr), .bus_wdata_o(b_wd), .bus_ack_i(ack), .bus_rdata_i(rd)
    );

    mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid64), .req_ready_o(ready64), .req_write_i(we),
        .req_size_i(size), .req_sign_ext_i(sign), .req_addr_i(addr), .req_wdata_i(wd64),
        .rsp_valid_o(rsp_v64), .rsp_err_o(rsp_e64), .rsp_rdata_o(rsp_d64), .bus_en_o(b_en64), .bus_we_o(b_we64),
        .bus_sel_o(b_sel64), .bus_addr_o(b_addr64), .bus_wdata_o(b_wd64), .bus_ack_i(ack64), .bus_rdata_i(rd64)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model helpers: plain arithmetic on byte counts and offsets for a 32-bit bus
    function automatic bit m_legal(input logic [1:0] s, input logic [31:0] a);
        return s != 2'd3 && (a % (32'd1 << s)) == 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [1:0] s, input logic [31:0] a);
        longint unsigned n = longint'(1) << s;
        return 4'(((longint'(1) << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_place(input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
        longint unsigned lim = longint'(1) << (8 * (1 << s));
        return 32'((longint'(w) % lim) << (8 * (a % 4)));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] raw, input logic [31:0] a, input logic [1:0] s, input logic sg);
        longint unsigned lim = longint'(1) << (8 * (1 << s));
        longint unsigned v = (longint'(raw) >> (8 * (a % 4))) % lim;
        if (sg && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    int          m_phase = 0, m_cnt = 0;
    logic        m_err = 1'b0, m_we = 1'b0, m_sign = 1'b0;
    logic [1:0]  m_size = 2'd0;
    logic [31:0] m_a = 32'd0, m_rd = 32'd0, e_addr = 32'd0, e_wd = 32'd0;
    logic [3:0]  e_sel = 4'd0;

    // Transaction model: phase 0 waits for a request, 1 is on the bus, 2 is the response cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_cnt <= 0; m_err <= 1'b0; m_rd <= 32'd0;
        end else if (m_phase == 0) begin
            if (valid) begin
                if (m_legal(size, addr)) begin
                    m_phase <= 1; m_cnt <= 0; m_we <= we; m_size <= size; m_sign <= sign; m_a <= addr;
                    e_sel <= m_sel(size, addr); e_addr <= addr - (addr % 4); e_wd <= m_place(size, addr, wd);
                end else begin
                    m_phase <= 2; m_err <= 1'b1; m_rd <= 32'd0;
                end
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_phase <= 2; m_err <= 1'b0; m_rd <= m_we ? 32'd0 : m_load(rd, m_a, m_size, m_sign);
            end else if (m_cnt + 1 == TO) begin
                m_phase <= 2; m_err <= 1'b1; m_rd <= 32'd0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_phase <= 0;
        end
    end

    // Per-cycle compare of the 32-bit unit against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("req_ready", ready, m_phase == 0);
            check("bus_en", b_en, m_phase == 1);
            check("rsp_valid", rsp_v, m_phase == 2);
            check("rsp_err", rsp_e, m_err);
            check("rsp_rdata", rsp_d, m_rd);
            if (m_phase == 1) begin
                check("bus_we", b_we, m_we);
                check("bus_sel", b_sel, e_sel);
                check("bus_addr", b_addr, e_addr);
                if (m_we) check("bus_wdata", b_wd, e_wd);
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr, wdata, rdata;
        int          wt;
        logic        ack, err;
        logic [31:0] exp_rd;
        logic [3:0]  sel;
        logic [31:0] baddr, bwd;
        int          ben;
    } row_t;

    row_t rows[10] = '{
        '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000AB, 32'h0,        0, 1'b1, 1'b0, 32'h0,        4'h8, 32'h1000, 32'hAB000000, 1},
        '{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0,        32'h80011234, 0, 1'b1, 1'b0, 32'hFFFF8001, 4'hC, 32'h2000, 32'h0,        1},
        '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0,        32'h80011234, 2, 1'b1, 1'b0, 32'h00008001, 4'hC, 32'h2000, 32'h0,        3},
        '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h0,        4'h0, 32'h0,    32'h0,        0},
        '{1'b0, 2'd2, 1'b0, 32'h4000, 32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0,        4'hF, 32'h4000, 32'h0,        4},
        '{1'b0, 2'd2, 1'b0, 32'h4004, 32'h0,        32'hDEADBEEF, 3, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF, 32'h4004, 32'h0,        4},
        '{1'b1, 2'd1, 1'b0, 32'h5002, 32'h12345678, 32'h0,        1, 1'b1, 1'b0, 32'h0,        4'hC, 32'h5000, 32'h56780000, 2},
        '{1'b0, 2'd0, 1'b1, 32'h6001, 32'h0,        32'h0000F100, 0, 1'b1, 1'b0, 32'hFFFFFFF1, 4'h2, 32'h6000, 32'h0,        1},
        '{1'b0, 2'd3, 1'b0, 32'h0000, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h0,        4'h0, 32'h0,    32'h0,        0},
        '{1'b0, 2'd0, 1'b0, 32'h6003, 32'h0,        32'h7F000000, 0, 1'b1, 1'b0, 32'h0000007F, 4'h8, 32'h6000, 32'h0,        1}
    };

    task automatic run_row(input row_t r);
        int k = 0, nb = 0;
        logic [3:0]  csel = 4'd0;
        logic [31:0] caddr = 32'd0, cwd = 32'd0;
        @(posedge clk); #1;
        we = r.we; size = r.size; sign = r.sign; addr = r.addr; wd = r.wdata; rd = r.rdata; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        while (!rsp_v && k < 300) begin
            if (b_en) begin
                nb++;
                if (nb == 1) begin csel = b_sel; caddr = b_addr; cwd = b_wd; end
            end
            ack = r.ack && k == r.wt;
            @(posedge clk); #1;
            ack = 1'b0;
            k++;
        end
        check("rsp_within_bound", k < 300, 1);
        check("row_err", rsp_e, r.err);
        check("row_rdata", rsp_d, r.exp_rd);
        check("row_bus_en_cycles", nb, r.ben);
        if (r.ben > 0) begin
            check("row_sel", csel, r.sel);
            check("row_addr", caddr, r.baddr);
            if (r.we) check("row_wdata", cwd, r.bwd);
        end
    endtask

    task automatic run64(input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [63:0] raw,
                         input logic [7:0] esel, input logic [31:0] eaddr, input logic [63:0] erd);
        @(posedge clk); #1;
        we = 1'b0; size = sz; sign = sg; addr = a; rd64 = raw; valid64 = 1'b1;
        @(posedge clk); #1;
        valid64 = 1'b0;
        check("bus_en64", b_en64, 1);
        check("bus_sel64", b_sel64, esel);
        check("bus_addr64", b_addr64, eaddr);
        ack64 = 1'b1;
        @(posedge clk); #1;
        ack64 = 1'b0;
        check("rsp_valid64", rsp_v64, 1);
        check("rsp_err64", rsp_e64, 0);
        check("rsp_rdata64", rsp_d64, erd);
        @(posedge clk); #1;
        check("rsp_pulse64", rsp_v64, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_bus_en", b_en, 0);
        check("rst_bus_we", b_we, 0);
        check("rst_bus_sel", b_sel, 0);
        check("rst_bus_addr", b_addr, 0);
        check("rst_bus_wdata", b_wd, 0);
        check("rst_rsp_valid", rsp_v, 0);
        check("rst_rsp_err", rsp_e, 0);
        check("rst_rsp_rdata", rsp_d, 0);
        check("rst_ready64", ready64, 1);
        #2 rst_n = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 ack = 1'b0;
        for (int i = 0; i < 10; i++) run_row(rows[i]);
        @(posedge clk); #1;
        we = 1'b0; size = 2'd2; sign = 1'b0; addr = 32'h7000; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("abort_busy", b_en, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_bus_en", b_en, 0);
        check("abort_ready", ready, 1);
        check("abort_rsp_valid", rsp_v, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("abort_no_rsp", rsp_v, 0);
        run_row(rows[0]);
        run64(2'd3, 1'b0, 32'h8, 64'h0123456789ABCDEF, 8'hFF, 32'h8, 64'h0123456789ABCDEF);
        run64(2'd0, 1'b1, 32'hF, 64'h8000000000000000, 8'h80, 32'h8, 64'hFFFFFFFFFFFFFF80);
        run64(2'd2, 1'b1, 32'h14, 64'hF000000000000000, 8'hF0, 32'h10, 64'hFFFFFFFFF0000000);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
